div_2in_seq: RTL
================

Name: div_2in_seq

Overview:
Sequential signed fixed-point divider, the inverse operation of the team's combinational Q(DWIDTH-frac).frac multiplier; computes Out = A / B in the same number format (default Q8.24). It is used wherever the sigmoid and normalisation datapath must divide rather than multiply. It is iterative: one restoring-division step per clock, with a start/busy/done handshake, so it avoids a large combinational divider.

Parameters:
DWIDTH, 32, total operand and result width, two's complement
frac, 24, fractional bits of A, B and Out

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when busy=0
A  input  DWIDTH  signed dividend; sampled with start
B  input  DWIDTH  signed divisor; sampled with start
busy  output  1  operation in progress
done  output  1  one-cycle pulse; Out and div_by_zero are valid
Out  output  DWIDTH  signed quotient; held until the next completion
div_by_zero  output  1  last operation had B=0; updated with done

Behaviour:
- Reset, asynchronous, rst_n=0: state=IDLE; Out=0, busy=0, done=0, div_by_zero=0; all internal registers cleared. Reset mid-operation aborts the operation with no done pulse.
- States:
  - IDLE -> CALC on start=1 with B!=0.
  - IDLE -> FIX on start=1 with B=0.
  - CALC -> FIX after N = DWIDTH+frac iterations.
  - FIX -> IDLE unconditionally.
- Capture (start edge):
  - Latch sign = A[MSB] xor B[MSB].
  - Latch |A| and |B| as DWIDTH-bit unsigned values. |-2^(DWIDTH-1)| = 2^(DWIDTH-1) must be representable.
  - Dividend = |A| << frac, N bits wide. Clear the remainder (DWIDTH+1 bits) and the iteration counter. busy=1.
- CALC: each cycle, shift the next dividend MSB into the remainder. If remainder >= |B|, subtract |B| and shift in quotient bit 1; otherwise shift in 0. The counter counts 0..N-1.
- FIX, one cycle:
  - Truncate the magnitude quotient q toward zero.
  - Positive result: saturate to 2^(DWIDTH-1)-1 if q exceeds it.
  - Negative result: saturate to -2^(DWIDTH-1) if q > 2^(DWIDTH-1); otherwise Out = -q.
  - A=0 gives Out=0 regardless of sign.
  - Register Out and div_by_zero. done=1 and busy=0 become visible in the cycle after FIX (first IDLE cycle).
- Divide by zero: Out = 2^(DWIDTH-1)-1 if A>0, -2^(DWIDTH-1) if A<0, 0 if A=0; div_by_zero=1.
- Latency, start edge at t:
  - Normal: done high in the cycle after edge t+N+1 (N+2 cycles from the start cycle; 58 at defaults).
  - B=0: done high after edge t+1 (2 cycles).
- start while busy=1: ignored, no queuing; A and B changes are also ignored.
- start is accepted in the same cycle done=1 (busy=0 there), giving back-to-back operation.
- done is exactly one cycle wide. Out and div_by_zero are stable from done until the next FIX.

Optional Feature:
Macro DIV_ROUND_EN.
- Defined: in FIX, if 2*remainder >= |B|, add 1 to q before sign and saturation (round half away from zero). Saturation still applies after rounding.
- Undefined: truncation toward zero; the remainder is not used in FIX.
- Latency is identical in both builds.

Test Plan:
- A=0x03000000 (3.0), B=0x02000000 (2.0), start -> done exactly 58 cycles after the start cycle (done in the 58th cycle, start cycle counted as 1). Out=0x01800000, div_by_zero=0, busy high until done.
- A=0xFF000000 (-1.0), B=0x03000000 -> Out=0xFFAAAAAB (both builds). A=0x02000000, B=0x03000000 -> Out=0x00AAAAAA; with DIV_ROUND_EN Out=0x00AAAAAB.
- A=0x7F000000 (127.0), B=0x00800000 (0.5) -> Out=0x7FFFFFFF. A=0x80000000, B=0xFF000000 (-1.0) -> Out=0x7FFFFFFF.
- A=0xFE000000 (-2.0), B=0 -> done in the 2nd cycle, Out=0x80000000, div_by_zero=1. A=0, B=0 -> Out=0, div_by_zero=1.
- Pulse start again at cycle 10 of an operation with different A and B -> ignored; result matches the first operands. New start in the done cycle -> accepted; second result correct after another 58 cycles.
- rst_n=0 at cycle 20 of CALC -> Out, busy, done, div_by_zero=0 immediately, no done pulse. After release, a 1.0/1.0 request -> Out=0x01000000.

Source files
------------

// File: rtl/div_2in_seq.sv
// div_2in_seq: sequential signed fixed-point divider, Out = A / B.
//
// The operands and the result share one two's-complement format with DWIDTH
// bits in total and `frac` fractional bits (Q8.24 by default). Division is
// done on magnitudes by a restoring divider that resolves one quotient bit per
// clock. The sign is applied and the result saturated in a final fix-up cycle.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request, sampled only while idle (busy=0)
//   A            signed dividend, captured with start
//   B            signed divisor, captured with start
//   busy         operation in progress
//   done         one-cycle pulse, Out and div_by_zero are valid
//   Out          signed quotient, held until the next completion
//   div_by_zero  the last operation had B=0, updated with done
//
// Optional feature (macro DIV_ROUND_EN):
//   defined   - round half away from zero using the final remainder
//   undefined - truncate toward zero (default)
// Latency is the same in both builds.

module div_2in_seq #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned frac   = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DWIDTH-1:0] A,
  input  logic [DWIDTH-1:0] B,
  output logic              busy,
  output logic              done,
  output logic [DWIDTH-1:0] Out,
  output logic              div_by_zero
);

  // One iteration per dividend bit: the dividend is |A| << frac.
  localparam int unsigned N    = DWIDTH + frac;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  localparam logic [CntW-1:0]   LastCnt = CntW'(N - 1);
  localparam logic [DWIDTH-1:0] MaxOut  = {1'b0, {(DWIDTH - 1){1'b1}}};
  localparam logic [DWIDTH-1:0] MinOut  = {1'b1, {(DWIDTH - 1){1'b0}}};
  // Largest magnitudes representable for a positive / negative result.
  localparam logic [N:0]        PosLim  = (N + 1)'((64'd1 << (DWIDTH - 1)) - 64'd1);
  localparam logic [N:0]        NegLim  = (N + 1)'(64'd1 << (DWIDTH - 1));

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StFix  = 2'd2
  } state_e;

  state_e state_q, state_d;

  // dq_q starts as the dividend; each step shifts one dividend bit out of the
  // top and one quotient bit in at the bottom, so it ends as the quotient.
  logic [N-1:0]      dq_q, dq_d;
  logic [DWIDTH:0]   rem_q, rem_d;
  logic [DWIDTH-1:0] babs_q, babs_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              sign_q, sign_d;
  logic              a_neg_q, a_neg_d;
  logic              a_zero_q, a_zero_d;
  logic              b_zero_q, b_zero_d;
  logic [DWIDTH-1:0] out_q, out_d;
  logic              dbz_q, dbz_d;
  logic              done_q, done_d;

  // Capture-side helpers.
  logic [DWIDTH-1:0] a_abs;
  logic [DWIDTH-1:0] b_abs;
  logic [N-1:0]      dividend_init;

  // Iteration datapath.
  logic [DWIDTH:0]   rem_shift;
  logic [DWIDTH:0]   rem_sub;
  logic              q_bit;

  // Fix-up datapath.
  logic [N:0]        q_fix;
  logic [DWIDTH-1:0] out_fix;

  // The remainder stays below |B| after every restoring step, so its top bit
  // is never shifted out; it is only read by the rounding compare.
  logic              unused_rem_msb;
  assign unused_rem_msb = rem_q[DWIDTH];

  // Magnitudes as unsigned DWIDTH-bit values; |-2^(DWIDTH-1)| still fits.
  assign a_abs = A[DWIDTH-1] ? ('0 - A) : A;
  assign b_abs = B[DWIDTH-1] ? ('0 - B) : B;

  always_comb begin
    dividend_init                 = '0;
    dividend_init[N-1 -: DWIDTH]  = a_abs;
  end

  assign rem_shift = {rem_q[DWIDTH-1:0], dq_q[N-1]};
  assign q_bit     = (rem_shift >= {1'b0, babs_q});
  assign rem_sub   = rem_shift - {1'b0, babs_q};

  // Quotient magnitude, optionally rounded, before sign and saturation.
  always_comb begin
    q_fix = {1'b0, dq_q};
`ifdef DIV_ROUND_EN
    if ({rem_q, 1'b0} >= {2'b00, babs_q}) begin
      q_fix = q_fix + (N + 1)'(1);
    end
`endif
  end

  always_comb begin
    out_fix = '0;
    if (b_zero_q) begin
      if (a_zero_q) begin
        out_fix = '0;
      end else if (a_neg_q) begin
        out_fix = MinOut;
      end else begin
        out_fix = MaxOut;
      end
    end else if (!sign_q) begin
      out_fix = (q_fix > PosLim) ? MaxOut : q_fix[DWIDTH-1:0];
    end else begin
      // Negating exactly 2^(DWIDTH-1) yields MinOut, so no special case.
      out_fix = (q_fix > NegLim) ? MinOut : ('0 - q_fix[DWIDTH-1:0]);
    end
  end

  always_comb begin
    state_d  = state_q;
    dq_d     = dq_q;
    rem_d    = rem_q;
    babs_d   = babs_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    a_neg_d  = a_neg_q;
    a_zero_d = a_zero_q;
    b_zero_d = b_zero_q;
    out_d    = out_q;
    dbz_d    = dbz_q;
    done_d   = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          sign_d   = A[DWIDTH-1] ^ B[DWIDTH-1];
          a_neg_d  = A[DWIDTH-1];
          a_zero_d = (A == '0);
          b_zero_d = (B == '0);
          babs_d   = b_abs;
          dq_d     = dividend_init;
          rem_d    = '0;
          cnt_d    = '0;
          // A zero divisor skips the iterations; the fix-up cycle picks the
          // saturated result from the dividend sign.
          state_d  = (B == '0) ? StFix : StCalc;
        end
      end

      StCalc: begin
        rem_d = q_bit ? rem_sub : rem_shift;
        dq_d  = {dq_q[N-2:0], q_bit};
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d = StFix;
        end
      end

      StFix: begin
        out_d   = out_fix;
        dbz_d   = b_zero_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      dq_q     <= '0;
      rem_q    <= '0;
      babs_q   <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      a_neg_q  <= 1'b0;
      a_zero_q <= 1'b0;
      b_zero_q <= 1'b0;
      out_q    <= '0;
      dbz_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dq_q     <= dq_d;
      rem_q    <= rem_d;
      babs_q   <= babs_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      a_neg_q  <= a_neg_d;
      a_zero_q <= a_zero_d;
      b_zero_q <= b_zero_d;
      out_q    <= out_d;
      dbz_q    <= dbz_d;
      done_q   <= done_d;
    end
  end

  // busy drops in the first idle cycle, together with the done pulse.
  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign Out         = out_q;
  assign div_by_zero = dbz_q;

endmodule
